// File: rtl/hit_judge.sv
// Rhythm-game hit judge: debounced red/blue buttons are graded against the note
// at the judge position, producing score, combo and hit/miss statistics.
module hit_judge #(
  parameter logic [19:0] DEB_CYCLES  = 20'd500000,
  parameter logic [15:0] PERFECT_PTS = 16'd3,
  parameter logic [15:0] GOOD_PTS    = 16'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        red_button,
  input  logic        blue_button,
  input  logic        yellow_button,
  input  logic        start,
  input  logic        note_R_judge,
  input  logic        note_B_judge,
  input  logic [2:0]  offset,
  input  logic        finish,
  output logic        delete,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo,
  output logic [15:0] score,
  output logic [9:0]  hit_count,
  output logic [9:0]  miss_count,
  output logic        perfect_pulse,
  output logic        good_pulse,
  output logic        miss_pulse,
  output logic        in_result
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [1:0]  w_btn_raw;
  logic [1:0]  w_press;

  logic        w_play;
  logic        w_clear;
  logic        w_in_result_next;

  logic [2:0]  r_offset_d;
  logic        r_judged;
  logic        w_boundary;
  logic        w_note;
  logic        w_any_press;
  logic        w_match;
  logic        w_judge_ok;
  logic        w_hit;
  logic        w_wrong;
  logic        w_bnd_miss;
  logic        w_miss;
  logic        w_perfect;

  logic [7:0]  r_combo;
  logic [7:0]  r_max_combo;
  logic [15:0] r_score;
  logic [9:0]  r_hit_count;
  logic [9:0]  r_miss_count;
  logic        r_delete;
  logic        r_perfect;
  logic        r_good;
  logic        r_miss;
  logic        r_in_result;

  logic [7:0]  w_combo_inc;
  logic [15:0] w_pts;
  logic [16:0] w_score_sum;
  logic [15:0] w_score_sat;
  logic [9:0]  w_hit_inc;
  logic [9:0]  w_miss_inc;

  assign w_btn_raw = {blue_button, red_button};

  // Per-button synchronizer, debouncer and rising-edge press detector (0=red, 1=blue)
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic        r_s1;
      logic        r_s2;
      logic        r_db;
      logic        r_db_d;
      logic [19:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1   <= 1'b0;
          r_s2   <= 1'b0;
          r_db   <= 1'b0;
          r_db_d <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_s1   <= w_btn_raw[gi];
          r_s2   <= r_s1;
          r_db_d <= r_db;
          if (r_s2 == r_db) begin
            r_cnt <= '0;
          end else if (r_cnt >= DEB_CYCLES - 20'd1) begin
            r_db  <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
      end

      assign w_press[gi] = r_db & ~r_db_d;
    end
  endgenerate

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start)         w_state_next = S_PLAY;
      S_PLAY:   if (finish)        w_state_next = S_RESULT;
      S_RESULT: if (yellow_button) w_state_next = S_IDLE;
      default:                     w_state_next = S_IDLE;
    endcase
  end

  // FSM: output decode
  always_comb begin
    w_play           = (r_state == S_PLAY);
    w_clear          = (r_state == S_IDLE) || ((r_state == S_RESULT) && yellow_button);
    w_in_result_next = (w_state_next == S_RESULT);
  end

  // Judging; a boundary cycle only resolves the outgoing note and drops presses
  always_comb begin
    w_boundary  = w_play && (r_offset_d == 3'd6) && (offset == 3'd0);
    w_note      = note_R_judge | note_B_judge;
    w_any_press = |w_press;
    w_match     = (w_press == 2'b01 && note_R_judge) || (w_press == 2'b10 && note_B_judge);
    w_judge_ok  = w_play && !w_boundary && !r_judged && w_any_press && w_note;
    w_hit       = w_judge_ok && w_match;
    w_wrong     = w_judge_ok && !w_match;
    w_bnd_miss  = w_boundary && w_note && !r_judged;
    w_miss      = w_wrong || w_bnd_miss;
    w_perfect   = (offset >= 3'd2) && (offset <= 3'd4);
  end

  always_comb begin
    w_combo_inc = (r_combo == 8'd255) ? 8'd255 : r_combo + 8'd1;
    w_pts       = w_perfect ? PERFECT_PTS : GOOD_PTS;
    w_score_sum = {1'b0, r_score} + {1'b0, w_pts};
    w_score_sat = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
    w_hit_inc   = (r_hit_count == 10'd1023) ? 10'd1023 : r_hit_count + 10'd1;
    w_miss_inc  = (r_miss_count == 10'd1023) ? 10'd1023 : r_miss_count + 10'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_offset_d  <= 3'd0;
      r_delete    <= 1'b0;
      r_perfect   <= 1'b0;
      r_good      <= 1'b0;
      r_miss      <= 1'b0;
      r_in_result <= 1'b0;
    end else begin
      r_offset_d  <= offset;
      r_delete    <= w_hit;
      r_perfect   <= w_hit & w_perfect;
      r_good      <= w_hit & ~w_perfect;
      r_miss      <= w_miss;
      r_in_result <= w_in_result_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_judged <= 1'b0;
    end else if (w_clear) begin
      r_judged <= 1'b0;
    end else if (w_play) begin
      if (w_boundary) begin
        r_judged <= 1'b0;
      end else if (w_hit || w_wrong) begin
        r_judged <= 1'b1;
      end
    end
  end

  // Statistics hold outside PLAY and clear while idle or when leaving RESULT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_combo      <= 8'd0;
      r_max_combo  <= 8'd0;
      r_score      <= 16'd0;
      r_hit_count  <= 10'd0;
      r_miss_count <= 10'd0;
    end else if (w_clear) begin
      r_combo      <= 8'd0;
      r_max_combo  <= 8'd0;
      r_score      <= 16'd0;
      r_hit_count  <= 10'd0;
      r_miss_count <= 10'd0;
    end else if (w_play) begin
      if (w_hit) begin
        r_combo     <= w_combo_inc;
        r_score     <= w_score_sat;
        r_hit_count <= w_hit_inc;
        if (w_combo_inc > r_max_combo) begin
          r_max_combo <= w_combo_inc;
        end
      end else if (w_miss) begin
        r_combo      <= 8'd0;
        r_miss_count <= w_miss_inc;
      end
      if (finish) begin
        r_combo <= 8'd0;
      end
    end
  end

  assign delete        = r_delete;
  assign perfect_pulse = r_perfect;
  assign good_pulse    = r_good;
  assign miss_pulse    = r_miss;
  assign in_result     = r_in_result;
  assign combo         = r_combo;
  assign max_combo     = r_max_combo;
  assign score         = r_score;
  assign hit_count     = r_hit_count;
  assign miss_count    = r_miss_count;

endmodule

// File: tb/tb_hit_judge.sv
// Self-checking bench for hit_judge: directed scenarios plus randomized notes and
// presses, compared against a rule-level scoring model.
module tb_hit_judge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        red_button = 1'b0;
  logic        blue_button = 1'b0;
  logic        yellow_button = 1'b0;
  logic        start = 1'b0;
  logic        note_R_judge = 1'b0;
  logic        note_B_judge = 1'b0;
  logic [2:0]  offset = 3'd0;
  logic        finish = 1'b0;
  logic        delete;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic [15:0] score;
  logic [9:0]  hit_count;
  logic [9:0]  miss_count;
  logic        perfect_pulse;
  logic        good_pulse;
  logic        miss_pulse;
  logic        in_result;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_combo, m_max, m_score, m_hits, m_miss;
  bit m_judged, m_play;
  int ed, ep, eg, em;   // expected pulse counts for the latest action
  int cd, cp, cg, cm;   // observed pulse counts

  always #5 clk = ~clk;

  hit_judge #(
    .DEB_CYCLES (20'd4),
    .PERFECT_PTS(16'd3),
    .GOOD_PTS   (16'd1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .red_button   (red_button),
    .blue_button  (blue_button),
    .yellow_button(yellow_button),
    .start        (start),
    .note_R_judge (note_R_judge),
    .note_B_judge (note_B_judge),
    .offset       (offset),
    .finish       (finish),
    .delete       (delete),
    .combo        (combo),
    .max_combo    (max_combo),
    .score        (score),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .perfect_pulse(perfect_pulse),
    .good_pulse   (good_pulse),
    .miss_pulse   (miss_pulse),
    .in_result    (in_result)
  );

  function automatic void model_clear();
    m_combo = 0; m_max = 0; m_score = 0; m_hits = 0; m_miss = 0; m_judged = 0;
  endfunction

  function automatic void model_miss();
    em = 1;
    m_combo = 0;
    m_miss = (m_miss < 1023) ? m_miss + 1 : 1023;
  endfunction

  function automatic void model_press(input logic [1:0] mask);
    bit note, match;
    ed = 0; ep = 0; eg = 0; em = 0;
    note = note_R_judge || note_B_judge;
    if (!m_play || m_judged || !note || mask == 2'b00) return;
    match = (mask == 2'b01 && note_R_judge) || (mask == 2'b10 && note_B_judge);
    m_judged = 1;
    if (match) begin
      ed = 1;
      m_hits  = (m_hits < 1023) ? m_hits + 1 : 1023;
      m_combo = (m_combo < 255) ? m_combo + 1 : 255;
      if (m_combo > m_max) m_max = m_combo;
      if (offset >= 2 && offset <= 4) begin ep = 1; m_score += 3; end
      else begin eg = 1; m_score += 1; end
      if (m_score > 65535) m_score = 65535;
    end else begin
      model_miss();
    end
  endfunction

  function automatic void model_boundary();
    ed = 0; ep = 0; eg = 0; em = 0;
    if (m_play && (note_R_judge || note_B_judge) && !m_judged) model_miss();
    m_judged = 0;
  endfunction

  // Press/hold/release one or both buttons and count output pulses seen meanwhile
  task automatic do_press(input logic [1:0] mask);
    cd = 0; cp = 0; cg = 0; cm = 0;
    @(negedge clk);
    red_button  = mask[0];
    blue_button = mask[1];
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 5) begin red_button = 1'b0; blue_button = 1'b0; end
      cd += int'(delete); cp += int'(perfect_pulse);
      cg += int'(good_pulse); cm += int'(miss_pulse);
    end
  endtask

  // Offset 6 -> 0 note boundary, counting pulses
  task automatic do_boundary();
    cd = 0; cm = 0;
    @(negedge clk); offset = 3'd6;
    @(negedge clk); offset = 3'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cd += int'(delete); cm += int'(miss_pulse);
    end
  endtask

  task automatic enter_play();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    model_clear();
    m_play = 1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({delete, perfect_pulse, good_pulse, miss_pulse, in_result} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses got %b exp 00000",
                         {delete, perfect_pulse, good_pulse, miss_pulse, in_result});
    end
    checks++;
    if ({combo, max_combo, score, hit_count, miss_count} !== 52'd0) begin
      errors++; $display("FAIL reset_counters got combo=%0d max=%0d score=%0d hit=%0d miss=%0d exp all 0",
                         combo, max_combo, score, hit_count, miss_count);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({combo, score, in_result, delete} !== 26'd0) begin
      errors++; $display("FAIL after_reset got combo=%0d score=%0d in_result=%b delete=%b exp 0",
                         combo, score, in_result, delete);
    end
    $display("test_reset done");
  endtask

  task automatic test_idle_ignored();
    note_R_judge = 1'b1; offset = 3'd3;
    do_press(2'b01);
    checks++;
    if (cd + cp + cg + cm != 0 || hit_count !== 10'd0) begin
      errors++; $display("FAIL idle_press got pulses=%0d hit=%0d exp 0 0", cd + cp + cg + cm, hit_count);
    end
    $display("test_idle_ignored: pulses=%0d", cd + cp + cg + cm);
  endtask

  task automatic test_perfect_hit();
    note_R_judge = 1'b1; note_B_judge = 1'b0; offset = 3'd3;
    enter_play();
    model_press(2'b01);
    do_press(2'b01);
    checks++;
    if (cd != 1 || cp != 1 || cg != 0 || cm != 0) begin
      errors++; $display("FAIL perfect_pulses got d=%0d p=%0d g=%0d m=%0d exp 1 1 0 0", cd, cp, cg, cm);
    end
    checks++;
    if (score !== 16'd3 || combo !== 8'd1 || hit_count !== 10'd1) begin
      errors++; $display("FAIL perfect_counts got score=%0d combo=%0d hit=%0d exp 3 1 1", score, combo, hit_count);
    end
    $display("test_perfect_hit: delete=%0d score=%0d combo=%0d", cd, score, combo);
  endtask

  task automatic test_good_and_repeat();
    model_boundary();
    do_boundary();
    checks++;
    if (cm != 0) begin errors++; $display("FAIL judged_boundary miss got %0d exp 0", cm); end
    note_R_judge = 1'b0; note_B_judge = 1'b1; offset = 3'd0;
    model_press(2'b10);
    do_press(2'b10);
    checks++;
    if (cd != 1 || cg != 1 || cp != 0 || score !== 16'(m_score)) begin
      errors++; $display("FAIL good_hit got d=%0d g=%0d p=%0d score=%0d exp 1 1 0 %0d", cd, cg, cp, score, m_score);
    end
    model_press(2'b10);
    do_press(2'b10);
    checks++;
    if (cd + cg + cp + cm != 0 || score !== 16'(m_score)) begin
      errors++; $display("FAIL repeat_press got pulses=%0d score=%0d exp 0 %0d", cd + cg + cp + cm, score, m_score);
    end
    $display("test_good_and_repeat: score=%0d", score);
  endtask

  task automatic test_wrong_colour();
    while (m_combo < 5) begin
      model_boundary(); do_boundary();
      note_R_judge = 1'b1; note_B_judge = 1'b0; offset = 3'd3;
      model_press(2'b01); do_press(2'b01);
    end
    model_boundary(); do_boundary();
    note_R_judge = 1'b1; note_B_judge = 1'b0; offset = 3'd3;
    model_press(2'b10);
    do_press(2'b10);
    checks++;
    if (cm != 1 || cd != 0 || cp + cg != 0) begin
      errors++; $display("FAIL wrong_pulses got m=%0d d=%0d pg=%0d exp 1 0 0", cm, cd, cp + cg);
    end
    checks++;
    if (combo !== 8'd0 || max_combo !== 8'd5 || miss_count !== 10'd1) begin
      errors++; $display("FAIL wrong_counts got combo=%0d max=%0d miss=%0d exp 0 5 1", combo, max_combo, miss_count);
    end
    $display("test_wrong_colour: combo=%0d max=%0d miss=%0d", combo, max_combo, miss_count);
  endtask

  task automatic test_boundary_miss();
    model_boundary(); do_boundary();
    note_R_judge = 1'b1; note_B_judge = 1'b0; offset = 3'd2;
    model_press(2'b01); do_press(2'b01);  // rebuild a combo first
    model_boundary(); do_boundary();      // note judged: no miss
    offset = 3'd2;
    model_boundary();
    do_boundary();
    checks++;
    if (cm != 1 || combo !== 8'd0 || miss_count !== 10'(m_miss)) begin
      errors++; $display("FAIL boundary_miss got m=%0d combo=%0d miss=%0d exp 1 0 %0d", cm, combo, miss_count, m_miss);
    end
    // Press whose event lands exactly on the boundary cycle
    offset = 3'd1;
    @(negedge clk); red_button = 1'b1;
    repeat (5) @(negedge clk);
    offset = 3'd6;
    @(negedge clk); offset = 3'd0; red_button = 1'b0;
    model_boundary();
    cd = 0; cm = 0; cp = 0; cg = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cd += int'(delete); cm += int'(miss_pulse); cp += int'(perfect_pulse); cg += int'(good_pulse);
    end
    checks++;
    if (cm != 1 || cd != 0 || cp + cg != 0 || hit_count !== 10'(m_hits)) begin
      errors++; $display("FAIL dropped_press got m=%0d d=%0d pg=%0d hit=%0d exp 1 0 0 %0d",
                         cm, cd, cp + cg, hit_count, m_hits);
    end
    $display("test_boundary_miss: misses=%0d hits=%0d", miss_count, hit_count);
  endtask

  task automatic test_simultaneous();
    model_boundary(); do_boundary();
    note_R_judge = 1'b0; note_B_judge = 1'b0; offset = 3'd3;
    model_press(2'b11); do_press(2'b11);
    checks++;
    if (cd + cp + cg + cm != 0) begin
      errors++; $display("FAIL both_no_note got pulses=%0d exp 0", cd + cp + cg + cm);
    end
    note_B_judge = 1'b1;
    model_press(2'b11); do_press(2'b11);
    checks++;
    if (cm != 1 || cd != 0 || miss_count !== 10'(m_miss)) begin
      errors++; $display("FAIL both_with_note got m=%0d d=%0d miss=%0d exp 1 0 %0d", cm, cd, miss_count, m_miss);
    end
    $display("test_simultaneous: miss=%0d", miss_count);
  endtask

  task automatic test_bounce();
    model_boundary(); do_boundary();
    note_R_judge = 1'b1; note_B_judge = 1'b0; offset = 3'd3;
    cd = 0; cp = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); red_button = 1'b1;
      repeat (3) @(negedge clk);
      red_button = 1'b0;
      cd += int'(delete);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); cd += int'(delete); cp += int'(perfect_pulse);
    end
    checks++;
    if (cd + cp != 0 || hit_count !== 10'(m_hits)) begin
      errors++; $display("FAIL bounce got pulses=%0d hit=%0d exp 0 %0d", cd + cp, hit_count, m_hits);
    end
    $display("test_bounce: hits=%0d", hit_count);
  endtask

  task automatic test_random();
    logic [1:0] sel, mask;
    int np;
    for (int it = 0; it < 40; it++) begin
      model_boundary(); do_boundary();
      checks++;
      if (cm != em || cd != 0) begin
        errors++; $display("FAIL rnd_boundary it=%0d got m=%0d d=%0d exp %0d 0", it, cm, cd, em);
      end
      sel = 2'($urandom_range(0, 3));
      note_R_judge = sel[0]; note_B_judge = sel[1];
      offset = 3'($urandom_range(0, 5));
      np = $urandom_range(1, 2);
      for (int p = 0; p < np; p++) begin
        mask = 2'($urandom_range(1, 3));
        model_press(mask);
        do_press(mask);
        checks++;
        if (cd != ed || cp != ep || cg != eg || cm != em) begin
          errors++; $display("FAIL rnd_pulses it=%0d mask=%b got d%0d p%0d g%0d m%0d exp d%0d p%0d g%0d m%0d",
                             it, mask, cd, cp, cg, cm, ed, ep, eg, em);
        end
      end
      checks++;
      if (combo !== 8'(m_combo) || max_combo !== 8'(m_max) || score !== 16'(m_score) ||
          hit_count !== 10'(m_hits) || miss_count !== 10'(m_miss)) begin
        errors++; $display("FAIL rnd_counts it=%0d got %0d/%0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d/%0d", it,
                           combo, max_combo, score, hit_count, miss_count,
                           m_combo, m_max, m_score, m_hits, m_miss);
      end
    end
    $display("test_random: score=%0d hits=%0d misses=%0d", score, hit_count, miss_count);
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 1030; n++) begin
      model_boundary(); do_boundary();
      note_R_judge = 1'b1; note_B_judge = 1'b0; offset = 3'd3;
      model_press(2'b01); do_press(2'b01);
      if (n == 299) begin
        checks++;
        if (combo !== 8'd255 || max_combo !== 8'd255) begin
          errors++; $display("FAIL combo_sat got combo=%0d max=%0d exp 255 255", combo, max_combo);
        end
      end
    end
    checks++;
    if (hit_count !== 10'd1023 || score !== 16'(m_score) || combo !== 8'd255) begin
      errors++; $display("FAIL hit_sat got hit=%0d score=%0d combo=%0d exp 1023 %0d 255",
                         hit_count, score, combo, m_score);
    end
    $display("test_saturation: hit=%0d combo=%0d max=%0d", hit_count, combo, max_combo);
  endtask

  task automatic test_result();
    @(negedge clk); finish = 1'b1;
    @(negedge clk); finish = 1'b0;
    m_combo = 0; m_play = 0;
    checks++;
    if (in_result !== 1'b1 || combo !== 8'd0) begin
      errors++; $display("FAIL result_entry got in_result=%b combo=%0d exp 1 0", in_result, combo);
    end
    do_press(2'b01);
    checks++;
    if (cd + cp + cg + cm != 0 || score !== 16'(m_score) || max_combo !== 8'd255 ||
        hit_count !== 10'(m_hits) || miss_count !== 10'(m_miss)) begin
      errors++; $display("FAIL result_hold got pulses=%0d score=%0d max=%0d hit=%0d miss=%0d exp 0 %0d 255 %0d %0d",
                         cd + cp + cg + cm, score, max_combo, hit_count, miss_count, m_score, m_hits, m_miss);
    end
    @(negedge clk); yellow_button = 1'b1;
    @(negedge clk); yellow_button = 1'b0;
    model_clear();
    checks++;
    if (in_result !== 1'b0 || {combo, max_combo, score, hit_count, miss_count} !== 52'd0) begin
      errors++; $display("FAIL result_exit got in_result=%b score=%0d hit=%0d miss=%0d max=%0d exp all 0",
                         in_result, score, hit_count, miss_count, max_combo);
    end
    $display("test_result: in_result=%b score=%0d", in_result, score);
  endtask

  task automatic test_reset_mid_play();
    note_R_judge = 1'b1; note_B_judge = 1'b0; offset = 3'd3;
    enter_play();
    model_press(2'b01); do_press(2'b01);
    model_boundary(); do_boundary();
    offset = 3'd3;
    @(negedge clk); red_button = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({delete, perfect_pulse, good_pulse, miss_pulse, in_result} !== 5'b0 ||
        {combo, max_combo, score, hit_count, miss_count} !== 52'd0) begin
      errors++; $display("FAIL async_reset got score=%0d hit=%0d combo=%0d exp 0 0 0", score, hit_count, combo);
    end
    m_play = 0; model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cd = 0; cp = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 8) red_button = 1'b0;
      cd += int'(delete); cp += int'(perfect_pulse);
    end
    checks++;
    if (cd + cp != 0 || hit_count !== 10'd0 || in_result !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got pulses=%0d hit=%0d in_result=%b exp 0 0 0", cd + cp, hit_count, in_result);
    end
    $display("test_reset_mid_play: pulses=%0d", cd + cp);
  endtask

  initial begin
    model_clear();
    m_play = 0;
    test_reset();
    test_idle_ignored();
    test_perfect_hit();
    test_good_and_repeat();
    test_wrong_colour();
    test_boundary_miss();
    test_simultaneous();
    test_bounce();
    test_random();
    test_saturation();
    test_result();
    test_reset_mid_play();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
